vm_timeout_ctrl: RTL and testbench
==================================

# vm_timeout_ctrl

Multi-channel timeout controller for the vending machine. Owns one free-running prescaler that derives a periodic tick enable from `clk`, and shares it among NCH independent countdown channels (dispense, refund, display, idle timeout). It also generates the display blink square wave. FSM blocks request timeouts here instead of instantiating private dividers.

## Interface
- `DIV`, 10_000_000: clk cycles per tick (100 ms at 100 MHz); must be ≥ 2.
- `NCH`, 4: number of countdown channels.
- `CW`, 8: countdown width in ticks (max 255 ticks).
- `BLINK_TICKS`, 5: ticks per blink half-period.

Ports:
- `clk`  in  1  system clock.
- `clr`  in  1  reset, asynchronous, active-high.
- `start`  in  NCH  per-channel start/restart request, level sampled each cycle.
- `cancel`  in  NCH  per-channel abort.
- `load_val`  in  NCH*CW  per-channel timeout in ticks; channel i uses bits [i*CW +: CW].
- `busy`  out  NCH  channel i is counting.
- `expire`  out  NCH  one-cycle pulse when channel i times out.
- `rd_sel`  in  $clog2(NCH)  channel selected for readback.
- `rd_val`  out  CW  remaining ticks of the selected channel (0 when idle).
- `tick`  out  1  one-cycle tick enable, exported to other blocks.
- `blink`  out  1  square wave that toggles every BLINK_TICKS ticks.

## Operation
- Prescaler: counts 0..DIV-1 and wraps. `tick`=1 in the cycle where the prescaler equals DIV-1. It is free-running and is never reset by `start` or `cancel`.
- Blink: a counter counts 0..BLINK_TICKS-1 on `tick`. `blink` toggles on the tick where that counter wraps.
- Per-channel FSM has two states, IDLE and RUN. Priority per cycle: `cancel` > `start` > `tick`.
  - IDLE + `start`, `load_val`=0: stay IDLE; `expire` pulses next cycle.
  - IDLE + `start`, `load_val`=N>0: go to RUN with count=N.
  - RUN + `cancel`: go to IDLE, count=0, no `expire`.
  - RUN + `start`: restart. Reload count from `load_val`, ignoring any concurrent `tick`. A value of 0 behaves as in IDLE.
  - RUN + `tick`, count>1: count-1.
  - RUN + `tick`, count==1: go to IDLE, count=0, `expire` pulses next cycle.
- A level-held `start` restarts the channel every cycle; requesters must pulse it.
- IDLE + `cancel` has no effect. `cancel`+`start` in the same cycle gives IDLE with no expire.
- Channels are fully independent. Any combination may expire on the same cycle.
- `rd_val` is a combinational mux of the count for the `rd_sel` channel. An out-of-range `rd_sel` gives 0.

## Timing
- Reset values: prescaler=0, blink counter=0, all counts=0, all channels IDLE, `busy`=0, `expire`=0, `tick`=0, `blink`=0, `rd_val`=0.
- `busy` is registered and high from the cycle after an accepted `start` (N>0) until the cycle after the final tick.
- `expire` is registered and is exactly 1 cycle wide. It is high in the cycle after the expiring tick, in the same cycle that `busy` falls.
- Timeout latency from `start` to `expire` is between (N-1)·DIV+1 and N·DIV cycles, because the first tick is partial.
- `clr` mid-count aborts all channels silently (no `expire`) and restarts the prescaler phase.

## Structure
- Package `vm_timer_pkg` holds:
  - the `NCH`, `CW`, `DIV` and `BLINK_TICKS` defaults;
  - the channel index constants `CH_DISPENSE`=0, `CH_REFUND`=1, `CH_DISPLAY`=2, `CH_IDLE`=3;
  - the channel state enum {IDLE, RUN}.
- Sub-module `vm_tick_gen` contains the prescaler and blink logic and outputs `tick` and `blink`.
- The top level instantiates `vm_tick_gen` once and uses a generate loop for the NCH channel FSMs.

## Test plan
All scenarios use DIV=4, CW=8, BLINK_TICKS=2.
- Reset release: `tick` appears every 4 cycles, first on cycle 4. `blink` toggles every 8 cycles. All other outputs are 0.
- Ch0 `start` with `load_val`=3, issued just after a tick: `busy`[0] is high, `rd_val` counts 3,2,1,0 on successive ticks, and a single `expire`[0] pulse lands 12 cycles after start.
- Ch1 `start` with N=5, then `cancel` after 2 ticks: `busy`[1] falls the next cycle, no `expire`[1], `rd_val`=0.
- Ch2 `start` with N=4, restarted with N=6 when count=1, coinciding with `tick`: count becomes 6 (not 5 or 0) and `expire` arrives 6 ticks later.
- `start` with N=0 on ch3: one `expire`[3] pulse on the next cycle, `busy`[3] never rises. Simultaneously, ch0 and ch1 started with equal N both expire on the same cycle.
- Assert `clr` mid-count on all channels: all outputs go to 0 immediately, with no `expire`. After release, the prescaler restarts from 0.

Source files
------------

// File: rtl/vm_timer_pkg.sv
// vm_timer_pkg: shared defaults, channel indices and channel state
// type for the vending-machine timeout controller.
package vm_timer_pkg;

   localparam int DEF_DIV         = 10_000_000;
   localparam int DEF_NCH         = 4;
   localparam int DEF_CW          = 8;
   localparam int DEF_BLINK_TICKS = 5;

   localparam int CH_DISPENSE = 0;
   localparam int CH_REFUND   = 1;
   localparam int CH_DISPLAY  = 2;
   localparam int CH_IDLE     = 3;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } ch_state_e;

endpackage

// File: rtl/vm_timeout_ctrl_if.sv
// vm_timeout_ctrl_if: request/status bundle between the FSM blocks
// (master) and the timeout controller (slave).
// Ports: start, cancel, load_val, rd_sel (to ctrl); busy, expire,
// rd_val (from ctrl).
interface vm_timeout_ctrl_if #(
   parameter int NCH = 4,
   parameter int CW  = 8
);
   localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;

   logic [NCH-1:0]    start;
   logic [NCH-1:0]    cancel;
   logic [NCH*CW-1:0] load_val;
   logic [NCH-1:0]    busy;
   logic [NCH-1:0]    expire;
   logic [SW-1:0]     rd_sel;
   logic [CW-1:0]     rd_val;

   modport master (
      output start, cancel, load_val, rd_sel,
      input  busy, expire, rd_val
   );

   modport slave (
      input  start, cancel, load_val, rd_sel,
      output busy, expire, rd_val
   );

endinterface

// File: rtl/vm_tick_gen.sv
// vm_tick_gen: free-running prescaler producing a one-cycle tick every
// DIV clocks, plus a blink square wave toggling every BLINK_TICKS ticks.
// Ports: clk, clr (async, active-high) in; tick, blink out.
module vm_tick_gen
   import vm_timer_pkg::*;
#(
   parameter int DIV         = DEF_DIV,
   parameter int BLINK_TICKS = DEF_BLINK_TICKS
) (
   input  logic clk,
   input  logic clr,
   output logic tick,
   output logic blink
);

   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

   logic [PW-1:0] pre_q, pre_d;
   logic [BW-1:0] bcnt_q, bcnt_d;
   logic          blink_q, blink_d;
   logic          tick_c;

   // Tick is decoded from the prescaler so it is 0 straight out of reset.
   assign tick_c = (pre_q == PW'(DIV - 1));

   always_comb begin
      pre_d   = tick_c ? '0 : pre_q + PW'(1);
      bcnt_d  = bcnt_q;
      blink_d = blink_q;
      if (tick_c) begin
         if (bcnt_q == BW'(BLINK_TICKS - 1)) begin
            bcnt_d  = '0;
            blink_d = ~blink_q;
         end else begin
            bcnt_d = bcnt_q + BW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         pre_q   <= '0;
         bcnt_q  <= '0;
         blink_q <= 1'b0;
      end else begin
         pre_q   <= pre_d;
         bcnt_q  <= bcnt_d;
         blink_q <= blink_d;
      end
   end

   assign tick  = tick_c;
   assign blink = blink_q;

endmodule

// File: rtl/vm_timeout_ctrl.sv
// vm_timeout_ctrl: NCH independent countdown channels sharing one tick.
// Ports: clk, clr (async, active-high); bus (slave side of the request
// interface); tick, blink exported to other blocks.
module vm_timeout_ctrl
   import vm_timer_pkg::*;
#(
   parameter int DIV         = DEF_DIV,
   parameter int NCH         = DEF_NCH,
   parameter int CW          = DEF_CW,
   parameter int BLINK_TICKS = DEF_BLINK_TICKS
) (
   input  logic             clk,
   input  logic             clr,
   vm_timeout_ctrl_if.slave bus,
   output logic             tick,
   output logic             blink
);

   logic          tick_w;
   logic [CW-1:0] cnt [NCH];
   logic [NCH-1:0] busy_v;
   logic [NCH-1:0] expire_v;
   logic [CW-1:0] rd_val_c;

   vm_tick_gen #(
      .DIV         (DIV),
      .BLINK_TICKS (BLINK_TICKS)
   ) u_tick_gen (
      .clk   (clk),
      .clr   (clr),
      .tick  (tick_w),
      .blink (blink)
   );

   assign tick = tick_w;

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      ch_state_e     state_q, state_d;
      logic [CW-1:0] cnt_q, cnt_d;
      logic          expire_q, expire_d;
      logic [CW-1:0] ld;

      assign ld = bus.load_val[i*CW +: CW];

      // cancel beats start beats tick; a start reload swallows a
      // coincident tick.
      always_comb begin
         state_d  = state_q;
         cnt_d    = cnt_q;
         expire_d = 1'b0;
         if (bus.cancel[i]) begin
            state_d = IDLE;
            cnt_d   = '0;
         end else if (bus.start[i]) begin
            if (ld == '0) begin
               state_d  = IDLE;
               cnt_d    = '0;
               expire_d = 1'b1;
            end else begin
               state_d = RUN;
               cnt_d   = ld;
            end
         end else if (state_q == RUN && tick_w) begin
            if (cnt_q == CW'(1)) begin
               state_d  = IDLE;
               cnt_d    = '0;
               expire_d = 1'b1;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
      end

      always_ff @(posedge clk or posedge clr) begin
         if (clr) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            expire_q <= 1'b0;
         end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            expire_q <= expire_d;
         end
      end

      assign busy_v[i]   = (state_q == RUN);
      assign expire_v[i] = expire_q;
      assign cnt[i]      = cnt_q;
   end

   // Unmatched selects fall through to 0.
   always_comb begin
      rd_val_c = '0;
      for (int i = 0; i < NCH; i++) begin
         if (int'(bus.rd_sel) == i) rd_val_c = cnt[i];
      end
   end

   assign bus.busy   = busy_v;
   assign bus.expire = expire_v;
   assign bus.rd_val = rd_val_c;

endmodule

// File: tb/tb_vm_timeout_ctrl.sv
// tb_vm_timeout_ctrl: directed scenarios plus randomized traffic checked
// against a tick-counting reference model.
module tb_vm_timeout_ctrl;

   localparam int DIV = 4;
   localparam int NCH = 4;
   localparam int CW  = 8;
   localparam int BT  = 2;

   logic clk = 1'b0;
   logic clr;
   logic tick;
   logic blink;

   int n_cmp = 0;
   int n_bad = 0;

   vm_timeout_ctrl_if #(.NCH(NCH), .CW(CW)) bus ();

   vm_timeout_ctrl #(
      .DIV         (DIV),
      .NCH         (NCH),
      .CW          (CW),
      .BLINK_TICKS (BT)
   ) dut (
      .clk   (clk),
      .clr   (clr),
      .bus   (bus),
      .tick  (tick),
      .blink (blink)
   );

   always #5 clk = ~clk;

   // Reference model: m_phase = clock edges since reset release,
   // m_rem = ticks still owed per channel (0 means idle).
   int             m_phase;
   int             m_rem [NCH];
   logic [NCH-1:0] m_exp;

   function automatic int ld_of(int i);
      return int'(bus.load_val[i*CW +: CW]);
   endfunction

   always @(posedge clk or posedge clr) begin
      if (clr) begin
         m_phase <= 0;
         for (int i = 0; i < NCH; i++) m_rem[i] <= 0;
         m_exp <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (bus.cancel[i]) begin
               m_rem[i] <= 0;
               m_exp[i] <= 1'b0;
            end else if (bus.start[i]) begin
               m_rem[i] <= ld_of(i);
               m_exp[i] <= (ld_of(i) == 0);
            end else if ((m_phase % DIV) == DIV - 1 && m_rem[i] > 0) begin
               m_rem[i] <= m_rem[i] - 1;
               m_exp[i] <= (m_rem[i] == 1);
            end else begin
               m_exp[i] <= 1'b0;
            end
         end
         m_phase <= m_phase + 1;
      end
   end

   task automatic set_ld(int ch, int v);
      bus.load_val[ch*CW +: CW] = CW'(v);
   endtask

   task automatic idle_inputs();
      bus.start    = '0;
      bus.cancel   = '0;
      bus.load_val = '0;
      bus.rd_sel   = '0;
   endtask

   // Leaves us at a negedge inside a tick cycle.
   task automatic align_tick();
      for (int k = 0; k < DIV + 1; k++) begin
         if ((m_phase % DIV) == DIV - 1) return;
         @(negedge clk);
      end
      n_cmp++;
      n_bad++;
      $display("FAIL align_tick: no tick phase within %0d cycles", DIV + 1);
   endtask

   task automatic test_reset();
      clr = 1'b1;
      idle_inputs();
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({bus.busy, bus.expire, bus.rd_val, tick, blink} !== '0) begin
         n_bad++;
         $display("FAIL reset_outs got busy=%b exp=%b rd=%0d tick=%b blink=%b want 0",
                  bus.busy, bus.expire, bus.rd_val, tick, blink);
      end
      clr = 1'b0;
      for (int j = 0; j < 40; j++) begin
         if (j > 0) @(negedge clk);
         n_cmp++;
         if (tick !== ((j % 4) == 3)) begin
            n_bad++;
            $display("FAIL reset_tick j=%0d got %b want %b", j, tick, (j % 4) == 3);
         end
         n_cmp++;
         if (blink !== (((j / 8) % 2) == 1)) begin
            n_bad++;
            $display("FAIL reset_blink j=%0d got %b want %b", j, blink,
                     ((j / 8) % 2) == 1);
         end
         n_cmp++;
         if ({bus.busy, bus.expire, bus.rd_val} !== '0) begin
            n_bad++;
            $display("FAIL reset_idle j=%0d got busy=%b exp=%b rd=%0d want 0",
                     j, bus.busy, bus.expire, bus.rd_val);
         end
      end
   endtask

   task automatic test_single();
      int exp_rd;
      align_tick();
      bus.rd_sel = 2'd0;
      set_ld(0, 3);
      bus.start[0] = 1'b1;
      for (int t = 0; t <= 16; t++) begin
         @(negedge clk);
         if (t == 0) bus.start[0] = 1'b0;
         exp_rd = (t < 4) ? 3 : (t < 8) ? 2 : (t < 12) ? 1 : 0;
         n_cmp++;
         if (bus.rd_val !== CW'(exp_rd)) begin
            n_bad++;
            $display("FAIL single_rd t=%0d got %0d want %0d", t, bus.rd_val, exp_rd);
         end
         n_cmp++;
         if (bus.busy[0] !== (t < 12)) begin
            n_bad++;
            $display("FAIL single_busy t=%0d got %b want %b", t, bus.busy[0], t < 12);
         end
         n_cmp++;
         if (bus.expire !== ((t == 12) ? 4'b0001 : 4'b0000)) begin
            n_bad++;
            $display("FAIL single_expire t=%0d got %b", t, bus.expire);
         end
      end
      idle_inputs();
   endtask

   task automatic test_cancel();
      int exp_rd;
      align_tick();
      bus.rd_sel = 2'd1;
      set_ld(1, 5);
      bus.start[1] = 1'b1;
      for (int t = 0; t <= 30; t++) begin
         @(negedge clk);
         exp_rd = (t < 4) ? 5 : (t < 8) ? 4 : (t < 9) ? 3 : 0;
         n_cmp++;
         if (bus.rd_val !== CW'(exp_rd)) begin
            n_bad++;
            $display("FAIL cancel_rd t=%0d got %0d want %0d", t, bus.rd_val, exp_rd);
         end
         n_cmp++;
         if (bus.busy[1] !== (t < 9)) begin
            n_bad++;
            $display("FAIL cancel_busy t=%0d got %b want %b", t, bus.busy[1], t < 9);
         end
         n_cmp++;
         if (bus.expire !== 4'b0000) begin
            n_bad++;
            $display("FAIL cancel_expire t=%0d got %b want 0000", t, bus.expire);
         end
         bus.start[1]  = 1'b0;
         bus.cancel[1] = (t == 8);
      end
      idle_inputs();
   endtask

   task automatic test_restart();
      int exp_rd;
      align_tick();
      bus.rd_sel = 2'd2;
      set_ld(2, 4);
      bus.start[2] = 1'b1;
      for (int t = 0; t <= 44; t++) begin
         @(negedge clk);
         exp_rd = (t < 16) ? 4 - t / 4 : (t < 40) ? 6 - (t - 16) / 4 : 0;
         n_cmp++;
         if (bus.rd_val !== CW'(exp_rd)) begin
            n_bad++;
            $display("FAIL restart_rd t=%0d got %0d want %0d", t, bus.rd_val, exp_rd);
         end
         n_cmp++;
         if (bus.busy[2] !== (t < 40)) begin
            n_bad++;
            $display("FAIL restart_busy t=%0d got %b want %b", t, bus.busy[2], t < 40);
         end
         n_cmp++;
         if (bus.expire !== ((t == 40) ? 4'b0100 : 4'b0000)) begin
            n_bad++;
            $display("FAIL restart_expire t=%0d got %b", t, bus.expire);
         end
         bus.start[2] = 1'b0;
         if (t == 15) begin
            // count is 1 and the tick is high this cycle
            set_ld(2, 6);
            bus.start[2] = 1'b1;
         end
      end
      idle_inputs();
   endtask

   task automatic test_simul();
      logic [NCH-1:0] exp_e;
      align_tick();
      bus.rd_sel = 2'd3;
      set_ld(0, 2);
      set_ld(1, 2);
      set_ld(3, 0);
      bus.start = 4'b1011;
      for (int t = 0; t <= 12; t++) begin
         @(negedge clk);
         bus.start = '0;
         exp_e = (t == 0) ? 4'b1000 : (t == 8) ? 4'b0011 : 4'b0000;
         n_cmp++;
         if (bus.expire !== exp_e) begin
            n_bad++;
            $display("FAIL simul_expire t=%0d got %b want %b", t, bus.expire, exp_e);
         end
         n_cmp++;
         if (bus.busy !== ((t < 8) ? 4'b0011 : 4'b0000)) begin
            n_bad++;
            $display("FAIL simul_busy t=%0d got %b", t, bus.busy);
         end
         n_cmp++;
         if (bus.rd_val !== '0) begin
            n_bad++;
            $display("FAIL simul_rd3 t=%0d got %0d want 0", t, bus.rd_val);
         end
      end
      idle_inputs();
   endtask

   task automatic test_random();
      logic [NCH-1:0] eb;
      for (int c = 0; c < 800; c++) begin
         @(negedge clk);
         for (int i = 0; i < NCH; i++) eb[i] = (m_rem[i] > 0);
         n_cmp++;
         if (tick !== ((m_phase % DIV) == DIV - 1)) begin
            n_bad++;
            $display("FAIL rnd_tick c=%0d got %b", c, tick);
         end
         n_cmp++;
         if (blink !== (((m_phase / DIV / BT) % 2) == 1)) begin
            n_bad++;
            $display("FAIL rnd_blink c=%0d got %b", c, blink);
         end
         n_cmp++;
         if (bus.busy !== eb) begin
            n_bad++;
            $display("FAIL rnd_busy c=%0d got %b want %b", c, bus.busy, eb);
         end
         n_cmp++;
         if (bus.expire !== m_exp) begin
            n_bad++;
            $display("FAIL rnd_expire c=%0d got %b want %b", c, bus.expire, m_exp);
         end
         n_cmp++;
         if (bus.rd_val !== CW'(m_rem[bus.rd_sel])) begin
            n_bad++;
            $display("FAIL rnd_rd c=%0d sel=%0d got %0d want %0d", c, bus.rd_sel,
                     bus.rd_val, m_rem[bus.rd_sel]);
         end
         for (int i = 0; i < NCH; i++) begin
            bus.start[i]  = ($urandom_range(0, 11) == 0);
            bus.cancel[i] = ($urandom_range(0, 29) == 0);
            set_ld(i, ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6));
         end
         bus.rd_sel = 2'($urandom_range(0, NCH - 1));
      end
      idle_inputs();
   endtask

   task automatic test_clr();
      for (int i = 0; i < NCH; i++) set_ld(i, 10);
      bus.start = '1;
      bus.rd_sel = 2'd1;
      @(negedge clk);
      bus.start = '0;
      repeat (5) @(negedge clk);
      n_cmp++;
      if (bus.busy !== 4'b1111) begin
         n_bad++;
         $display("FAIL clr_pre_busy got %b want 1111", bus.busy);
      end
      clr = 1'b1;
      #1;
      n_cmp++;
      if ({bus.busy, bus.expire, bus.rd_val, tick, blink} !== '0) begin
         n_bad++;
         $display("FAIL clr_async got busy=%b exp=%b rd=%0d tick=%b blink=%b want 0",
                  bus.busy, bus.expire, bus.rd_val, tick, blink);
      end
      repeat (2) @(negedge clk);
      clr = 1'b0;
      for (int j = 0; j < 50; j++) begin
         if (j > 0) @(negedge clk);
         n_cmp++;
         if (tick !== ((j % 4) == 3)) begin
            n_bad++;
            $display("FAIL clr_tick j=%0d got %b want %b", j, tick, (j % 4) == 3);
         end
         n_cmp++;
         if ({bus.busy, bus.expire, bus.rd_val} !== '0) begin
            n_bad++;
            $display("FAIL clr_silent j=%0d got busy=%b exp=%b rd=%0d want 0",
                     j, bus.busy, bus.expire, bus.rd_val);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_cancel();
      test_restart();
      test_simul();
      test_random();
      test_clr();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
